// File: rtl/seq_multop.sv
// ============================================================================
// Module   : seq_multop
// Brief    : Shift-and-add unsigned WIDTH x WIDTH multiplier, one multiplier
//            bit per clock, start/busy/done handshake. Optional macro
//            SEQ_MULTOP_EARLY_EXIT_EN finishes once no multiplier bits remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multop #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             carry
);

  localparam int               c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_last;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mplier_shr;
  logic [c_CNT_W-1:0]   w_cnt_next;

  logic                 r_done;
  logic [WIDTH-1:0]     r_out;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_carry;

  assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_shr = r_mplier >> 1;
  assign w_cnt_next   = r_cnt + c_CNT_W'(1);

`ifdef SEQ_MULTOP_EARLY_EXIT_EN
  // Stop as soon as the remaining multiplier bits cannot contribute.
  assign w_last = (w_cnt_next == c_LAST) || (w_mplier_shr == '0);
`else
  assign w_last = (w_cnt_next == c_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_cnt    <= w_cnt_next;
    end
  end

  // Results persist until the next finishing edge, even across a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_out   <= '0;
      r_hi    <= '0;
      r_carry <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_out   <= w_acc_next[WIDTH-1:0];
        r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
        r_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign out   = r_out;
  assign hi    = r_hi;
  assign carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_seq_multop.sv
// ============================================================================
// Module   : tb_seq_multop
// Brief    : Self-checking bench for seq_multop (WIDTH=4 and WIDTH=8 instances),
//            honours SEQ_MULTOP_EARLY_EXIT_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multop;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [3:0] A, B;
  logic       busy, done, carry;
  logic [3:0] out, hi;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, carry8;
  logic [7:0] out8, hi8;

  int checks = 0;
  int errors = 0;

  seq_multop #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .out(out), .hi(hi), .carry(carry)
  );

  seq_multop #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .out(out8), .hi(hi8), .carry(carry8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] e_out;
    logic [3:0] e_hi;
    logic       e_carry;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Latency from the operation rules: full width, or highest set bit + 1.
  function automatic int model_lat(input int w, input logic [31:0] b);
    int hb;
    hb = -1;
    for (int i = 0; i < w; i++) if (b[i]) hb = i;
`ifdef SEQ_MULTOP_EARLY_EXIT_EN
    return (hb + 1 < 1) ? 1 : hb + 1;
`else
    return w;
`endif
  endfunction

  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] e_out, input logic [3:0] e_hi,
                      input logic e_carry, input string name);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        lat  = k;
      end else if (busy) begin
        bcnt++;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end else begin
      chk({name, "_lat"},   lat,  model_lat(4, {28'd0, b}));
      chk({name, "_busy"},  bcnt, model_lat(4, {28'd0, b}));
      chk({name, "_out"},   {28'd0, out}, {28'd0, e_out});
      chk({name, "_hi"},    {28'd0, hi},  {28'd0, e_hi});
      chk({name, "_carry"}, {31'd0, carry}, {31'd0, e_carry});
      @(posedge clk); #1;
      chk({name, "_pulse"}, {31'd0, done}, 32'd0);
      chk({name, "_hold"},  {23'd0, carry, hi, out}, {23'd0, e_carry, e_hi, e_out});
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input string name);
    int lat;
    bit seen;
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        seen = 1;
        lat  = k;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end else begin
      chk({name, "_lat"},   lat, model_lat(8, {24'd0, b}));
      chk({name, "_prod"},  {16'd0, hi8, out8}, {16'd0, prod});
      chk({name, "_carry"}, {31'd0, carry8}, {31'd0, (prod >= 16'd256)});
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   t1, t2;
    bit   seen;
    logic [3:0] ra, rb;
    logic [7:0] prod;

    vecs[0] = '{4'd0,  4'd15, 4'd0,  4'd0,  1'b0};
    vecs[1] = '{4'd9,  4'd2,  4'd2,  4'd1,  1'b1};
    vecs[2] = '{4'd15, 4'd15, 4'd1,  4'd14, 1'b1};
    vecs[3] = '{4'd3,  4'd5,  4'd15, 4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd2,  4'd14, 4'd0,  1'b0};
    vecs[5] = '{4'd15, 4'd0,  4'd0,  4'd0,  1'b0};
    vecs[6] = '{4'd1,  4'd1,  4'd1,  4'd0,  1'b0};
    vecs[7] = '{4'd4,  4'd8,  4'd0,  4'd2,  1'b1};

    rst_n = 1'b0;
    start = 1'b0; A = '0; B = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_res",  {23'd0, carry, hi, out}, 32'd0);
    chk("reset_res8", {15'd0, carry8, hi8, out8}, 32'd0);

    for (int i = 0; i < 8; i++)
      run4(vecs[i].a, vecs[i].b, vecs[i].e_out, vecs[i].e_hi, vecs[i].e_carry,
           $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      prod = 8'(ra) * 8'(rb);
      run4(ra, rb, prod[3:0], prod[7:4], prod >= 8'd16, $sformatf("rnd%0d", i));
    end

    // start held high: second operands presented in the done cycle.
    @(negedge clk);
    A = 4'd3; B = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    A = 4'd15; B = 4'd15;
    seen = 0; t1 = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; t1 = k; end
    end
    chk("b2b_first_lat", t1, model_lat(4, 32'd5));
    chk("b2b_first_res", {27'd0, carry, out}, 32'd15);
    A = 4'd7; B = 4'd2;
    seen = 0; t2 = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin A = 4'd15; B = 4'd15; end
      if (done) begin seen = 1; t2 = k; end
    end
    start = 1'b0;
    chk("b2b_spacing", t2, model_lat(4, 32'd2) + 1);
    chk("b2b_second_res", {27'd0, carry, out}, 32'd14);
    @(posedge clk); #1;
    chk("b2b_stop", {31'd0, busy}, 32'd0);

    // Reset in the middle of a run.
    @(negedge clk);
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_outs", {22'd0, done, carry, hi, out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", {31'd0, seen}, 32'd0);
    run4(4'd2, 4'd3, 4'd6, 4'd0, 1'b0, "after_rst");

    run8(8'd200, 8'd200, "w8_200x200");
    run8(8'd200, 8'd1,   "w8_200x1");
    run8(8'd255, 8'd255, "w8_max");
    run8(8'd17,  8'd0,   "w8_zero");
    for (int i = 0; i < 6; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $sformatf("w8_rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_multop.md
# seq_multop

Sequential, parametrised successor to the nibble multiply unit in the ALU. Computes the unsigned product of two WIDTH-bit operands by shift-and-add, one multiplier bit per clock, under a start/busy/done handshake. It returns the low WIDTH bits, the high WIDTH bits and an overflow carry. This lets the datapath share one narrow adder instead of a full combinational array multiplier.

## Interface
- WIDTH, 4: operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- A  in  WIDTH  multiplicand; captured on the accepting edge.
- B  in  WIDTH  multiplier; captured on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- out  out  WIDTH  low half of the product.
- hi  out  WIDTH  high half of the product.
- carry  out  1  1 iff the full product ≥ 2^WIDTH, i.e. hi ≠ 0.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Transitions:
  - IDLE→RUN on an edge with start=1.
  - RUN→IDLE on the finishing edge.
- Accept edge:
  - Latch A into a 2·WIDTH-bit multiplicand register, zero-extended.
  - Latch B into a WIDTH-bit shift register.
  - Clear the 2·WIDTH-bit accumulator.
  - Clear the bit counter.
- Each RUN edge:
  - If mreg[0]=1, add the multiplicand register to the accumulator. The accumulator is 2·WIDTH bits wide, so the add never overflows.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- Finishing edge:
  - Register the final accumulator as {hi, out}.
  - carry = |hi.
  - Pulse done.
- Results are held unchanged until the next finishing edge. A new start does not clear them.
- start while busy=1 is ignored; operands are not re-sampled.
- start asserted in the cycle done is high is accepted, because busy=0 in that cycle.
- Reset (any time, including mid-RUN) forces IDLE. busy, done, out, hi and carry all go to 0, and the in-flight operation is discarded.

## Timing
- E0 denotes the accepting edge.
- Finishing edge is EW, i.e. edge WIDTH after E0 (baseline, macro undefined).
- busy is high from after E0 through to EW: exactly WIDTH cycles.
- done, out, hi and carry update at EW. done is high for the one cycle following EW.
- Back-to-back throughput: one result per WIDTH+1 cycles when start is held high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_MULTOP_EARLY_EXIT_EN
- Defined:
  - The finishing edge is the first RUN edge after which the remaining multiplier bits are all zero, or the counter reaches WIDTH, whichever is first.
  - Latency = max(1, index of the highest set bit of B + 1).
  - B=0 finishes at E1.
- Undefined: latency is always exactly WIDTH cycles, independent of the data.
- Results are identical in both builds; only latency differs.

## Test plan
- Reset, then A=0, B=15 (WIDTH=4) -> done after 4 cycles; out=0000, hi=0000, carry=0. With the macro: done at E4, because the highest set bit of B is bit 3.
- A=9, B=2 -> out=0010, hi=0001, carry=1. With the macro: finishes at E2.
- A=15, B=15 -> out=0001, hi=1110, carry=1. busy is high for exactly 4 cycles.
- start held high continuously, with operand pairs (3,5) then (7,2) -> results 15 (carry=0), then 14 (carry=0). done pulses are 5 cycles apart. Operands changed while busy are ignored.
- rst_n pulsed low at cycle 2 of a RUN with A=15, B=15 -> all outputs go to 0 immediately. No done follows. A next start with A=2, B=3 yields out=6.
- WIDTH=8, A=200, B=200 -> {hi,out}=40000 (hi=156, out=64), carry=1, latency 8. With the macro and B=1: latency 1, out=200, carry=0.
